// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine behind CPU register $4014.
// A CPU write of page P to $4014 halts the CPU. The engine then copies bytes
// P00..P(BYTE_COUNT-1) into OAM through the $2004 data port of mem_decode.
// Each byte takes one READ cycle and one WRITE cycle. All READ cycles land on
// even bus parity. While idle, the CPU bus passes straight through.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          BYTE_COUNT    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic [15:0] mem_addr_out,
    output logic [7:0]  mem_data_out,
    output logic        mem_write_en,
    output logic        mem_read_en,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_halt,
    output logic        dma_busy,
    output logic        dma_done
);

    // BYTE_COUNT is a power of two no larger than 256, so the final index fits in 8 bits
    localparam logic [7:0] LAST_IDX = 8'(BYTE_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic        cyc_odd;
    logic        done_q;
    logic        trigger;
    logic        last_byte;

    // Only a CPU write to the DMA register starts a transfer. Reads do not.
    assign trigger   = cpu_write_en && (cpu_addr_in == DMA_REG_ADDR);
    assign last_byte = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Page latch, byte index, free-running bus parity and completion flag
    always_ff @(posedge clk) begin
        if (rst) begin
            page    <= 8'h00;
            idx     <= 8'h00;
            cyc_odd <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cyc_odd <= ~cyc_odd;
            // The flag is set only by the last WRITE, so it is high for
            // exactly the first IDLE cycle after a completed transfer.
            done_q  <= (state == S_WRITE) && last_byte;
            if ((state == S_IDLE) && trigger) begin
                page <= cpu_data_in;
            end
            if (state == S_WRITE) begin
                idx <= last_byte ? 8'h00 : idx + 8'd1;
            end
        end
    end

    // Next-state logic. CPU inputs are ignored outside IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nxt = S_HALT;
                end
            end
            // The dummy halt cycle takes the parity into account. If the
            // following cycle would be odd, one extra ALIGN cycle is inserted.
            S_HALT: begin
                state_nxt = cyc_odd ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                state_nxt = S_READ;
            end
            S_READ: begin
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = last_byte ? S_IDLE : S_READ;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus mux and status outputs. In IDLE the block is a transparent
    // pass-through, so the triggering write itself still reaches mem_decode.
    always_comb begin
        mem_addr_out = cpu_addr_in;
        mem_data_out = cpu_data_in;
        mem_write_en = cpu_write_en;
        mem_read_en  = cpu_read_en;
        cpu_halt     = 1'b0;
        dma_busy     = 1'b0;
        case (state)
            S_HALT, S_ALIGN: begin
                mem_addr_out = {page, idx};
                mem_data_out = 8'h00;
                mem_write_en = 1'b0;
                mem_read_en  = 1'b0;
                cpu_halt     = 1'b1;
                dma_busy     = 1'b1;
            end
            S_READ: begin
                // {page, idx} is exactly 16 bits, so page FF ends at FFFF and never carries
                mem_addr_out = {page, idx};
                mem_data_out = 8'h00;
                mem_write_en = 1'b0;
                mem_read_en  = 1'b1;
                cpu_halt     = 1'b1;
                dma_busy     = 1'b1;
            end
            S_WRITE: begin
                // mem_decode returns registered read data, so the byte from the READ cycle is valid now
                mem_addr_out = OAM_DATA_ADDR;
                mem_data_out = mem_data_in;
                mem_write_en = 1'b1;
                mem_read_en  = 1'b0;
                cpu_halt     = 1'b1;
                dma_busy     = 1'b1;
            end
            default: begin
            end
        endcase
        // No bus strobes may leave the block while reset is held
        if (rst) begin
            mem_write_en = 1'b0;
            mem_read_en  = 1'b0;
        end
    end

    assign dma_done = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench for oam_dma, with a behavioural mem_decode/OAM model.
module tb_oam_dma;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic [15:0] mem_addr_out;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [7:0]  mem_data_in;
    logic        cpu_halt;
    logic        dma_busy;
    logic        dma_done;

    oam_dma dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr_in  (cpu_addr_in),
        .cpu_data_in  (cpu_data_in),
        .cpu_write_en (cpu_write_en),
        .cpu_read_en  (cpu_read_en),
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_data_in  (mem_data_in),
        .cpu_halt     (cpu_halt),
        .dma_busy     (dma_busy),
        .dma_done     (dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic tb_par = 1'b0;

    logic [7:0]  ram [0:65535];
    bit          written [0:65535];
    logic [7:0]  oam [0:255];
    logic [7:0]  oam_ptr = 8'h00;

    logic [15:0] rd_q[$];
    logic [7:0]  wd_q[$];

    // Unwritten RAM holds a preload pattern: byte = addr[7:0], inverted on page FF
    function automatic logic [7:0] pat(input logic [15:0] a);
        return (a[15:8] == 8'hFF) ? ~a[7:0] : a[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent bus parity: zero in the reset cycle, then toggles every clock
    always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

    always @(posedge clk) if (!rst && dma_done) done_cnt <= done_cnt + 1;

    // mem_decode stand-in: registered reads, $2004 writes into OAM with auto-increment.
    // The OAM pointer restarts on each $4014 trigger, as if the CPU had written $2003.
    always @(posedge clk) begin
        if (mem_read_en) mem_data_in <= written[mem_addr_out] ? ram[mem_addr_out] : pat(mem_addr_out);
        if (mem_write_en) begin
            if (mem_addr_out == 16'h2004) begin
                oam[oam_ptr] <= mem_data_out;
                oam_ptr <= oam_ptr + 8'd1;
            end else begin
                ram[mem_addr_out] <= mem_data_out;
                written[mem_addr_out] <= 1'b1;
            end
        end
        if (cpu_write_en && cpu_addr_in == 16'h4014 && !cpu_halt) oam_ptr <= 8'h00;
    end

    // Scoreboard: pop expected read addresses and write data as the DUT bus shows them
    always @(negedge clk) begin
        if (!rst && cpu_halt) begin
            if (mem_read_en) begin
                if (rd_q.size() == 0) check("rd_extra", 32'(rd_q.size()), 32'd1);
                else check("rd_addr", 32'(mem_addr_out), 32'(rd_q.pop_front()));
                check("rd_parity", 32'(tb_par), 32'd0);
            end
            if (mem_write_en) begin
                check("wr_addr", 32'(mem_addr_out), 32'h2004);
                if (wd_q.size() == 0) check("wr_extra", 32'(wd_q.size()), 32'd1);
                else check("wr_data", 32'(mem_data_out), 32'(wd_q.pop_front()));
            end
        end
    end

    // want: 0/1 = wait for that parity in the trigger cycle, 2 = trigger immediately.
    // poke: drive a second $4014 write mid-transfer. rst_after: >0 resets after that many writes.
    task automatic dma_run(input logic [7:0] pg, input int want, input bit poke, input int rst_after);
        int cnt;
        int wr;
        int d0;
        int exp_len;
        if (want != 2) begin
            do begin
                @(posedge clk); #1;
            end while (tb_par != want[0]);
        end
        exp_len = tb_par ? 514 : 513;
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            rd_q.push_back({pg, 8'(i)});
            wd_q.push_back(pat({pg, 8'(i)}));
        end
        cpu_write_en = 1'b1;
        cpu_read_en  = 1'b0;
        cpu_addr_in  = 16'h4014;
        cpu_data_in  = pg;
        @(posedge clk); #1;
        cpu_write_en = 1'b0;
        cnt = 0;
        wr = 0;
        while (cpu_halt && cnt < 600) begin
            if (poke && cnt == 50) begin
                cpu_write_en = 1'b1;
                cpu_addr_in  = 16'h4014;
                cpu_data_in  = 8'h07;
            end else begin
                cpu_write_en = 1'b0;
            end
            if (rst_after > 0 && wr == rst_after) begin
                rst = 1'b1;
                rd_q.delete();
                wd_q.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_halt", 32'(cpu_halt), 32'd0);
                check("rst_busy", 32'(dma_busy), 32'd0);
                check("rst_done", 32'(dma_done), 32'd0);
                check("rst_done_cnt", 32'(done_cnt), 32'(d0));
                return;
            end
            if (mem_write_en) wr++;
            cnt++;
            @(posedge clk); #1;
        end
        cpu_write_en = 1'b0;
        check("halt_len", 32'(cnt), 32'(exp_len));
        check("done_pulse", 32'(dma_done), 32'd1);
        check("busy_fall", 32'(dma_busy), 32'd0);
        check("rd_left", 32'(rd_q.size()), 32'd0);
        check("wd_left", 32'(wd_q.size()), 32'd0);
    endtask

    task automatic check_oam(input logic [7:0] pg);
        for (int i = 0; i < 256; i++) check("oam", 32'(oam[i]), 32'(pat({pg, 8'(i)})));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with bus strobes and a $4014 write held active
        rst = 1'b1;
        cpu_write_en = 1'b1;
        cpu_read_en  = 1'b1;
        cpu_addr_in  = 16'h4014;
        cpu_data_in  = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_we", 32'(mem_write_en), 32'd0);
        check("rst_mem_re", 32'(mem_read_en), 32'd0);
        check("rst_cpu_halt", 32'(cpu_halt), 32'd0);
        check("rst_dma_busy", 32'(dma_busy), 32'd0);
        check("rst_dma_done", 32'(dma_done), 32'd0);
        rst = 1'b0;
        cpu_write_en = 1'b0;
        cpu_read_en  = 1'b0;
        @(posedge clk); #1;
        check("post_rst_halt", 32'(cpu_halt), 32'd0);

        // Pass-through write and read-back
        cpu_write_en = 1'b1;
        cpu_addr_in  = 16'h0123;
        cpu_data_in  = 8'h5A;
        #1;
        check("pt_waddr", 32'(mem_addr_out), 32'h0123);
        check("pt_wdata", 32'(mem_data_out), 32'h5A);
        check("pt_we", 32'(mem_write_en), 32'd1);
        check("pt_halt", 32'(cpu_halt), 32'd0);
        @(posedge clk); #1;
        cpu_write_en = 1'b0;
        cpu_read_en  = 1'b1;
        #1;
        check("pt_raddr", 32'(mem_addr_out), 32'h0123);
        check("pt_re", 32'(mem_read_en), 32'd1);
        check("pt_we_off", 32'(mem_write_en), 32'd0);
        @(posedge clk); #1;
        cpu_read_en = 1'b0;
        check("pt_rdata", 32'(mem_data_in), 32'h5A);

        // A read of $4014 must not start a transfer
        cpu_read_en = 1'b1;
        cpu_addr_in = 16'h4014;
        @(posedge clk); #1;
        cpu_read_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rd4014_halt", 32'(cpu_halt), 32'd0);
            @(posedge clk); #1;
        end

        // Basic DMA on even trigger parity, then odd parity
        dma_run(8'h02, 0, 1'b0, 0);
        check_oam(8'h02);
        dma_run(8'h02, 1, 1'b0, 0);
        check_oam(8'h02);

        // Page FF: reads FF00..FFFF without carry
        dma_run(8'hFF, 0, 1'b0, 0);
        check_oam(8'hFF);

        // Back-to-back: the second trigger lands in the first IDLE cycle
        dma_run(8'h02, 1, 1'b0, 0);
        dma_run(8'hFF, 2, 1'b0, 0);
        check_oam(8'hFF);

        // A $4014 write during a transfer is ignored
        dma_run(8'h02, 0, 1'b1, 0);
        check_oam(8'h02);

        // Reset after 100 writes, then a fresh transfer
        dma_run(8'hFF, 1, 1'b0, 100);
        dma_run(8'h02, 0, 1'b0, 0);
        check_oam(8'h02);

        repeat (2) @(posedge clk);
        #1;
        check("done_total", 32'(done_cnt), 32'd7);
        check("halt_final", 32'(cpu_halt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
